// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
//
// Accepts one 512-bit message block and streams the 64 schedule words W_t
// together with the matching round constant K_t to a downstream round engine
// using a valid/ready handshake. Words 0..15 come straight from the block;
// words 16..63 are generated on the fly from a sliding 16-word window, so only
// one new word is computed per accepted transfer.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      load request, honoured only while ready=1
//   block_in   message block, M0 in [511:480] down to M15 in [31:0]
//   ready      high while idle; a start in this cycle is accepted
//   out_ready  downstream accepts the current word pair
//   valid      w_out/k_out/round_idx carry round t
//   w_out      schedule word W_t
//   k_out      round constant K_t
//   round_idx  round index t
//   last       high with valid for t = 63
//   done       one-cycle pulse after round 63 has been accepted
module sha256_msg_sched (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic         ready,
    input  logic         out_ready,
    output logic         valid,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   round_idx,
    output logic         last,
    output logic         done
);

    localparam int unsigned NumRounds = 64;
    localparam int unsigned WinDepth  = 16;

    // FIPS 180-4 round constants.
    localparam logic [31:0] KTable [NumRounds] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e      state_q;
    logic [31:0] win_q [WinDepth];
    logic [5:0]  t_q;
    logic        done_q;

    logic [31:0] ssig0_w1;
    logic [31:0] ssig1_w14;
    logic [31:0] w_new;

    // Small sigma functions on the window taps used by the recurrence.
    always_comb begin
        ssig0_w1  = {win_q[1][6:0], win_q[1][31:7]}
                  ^ {win_q[1][17:0], win_q[1][31:18]}
                  ^ (win_q[1] >> 3);
        ssig1_w14 = {win_q[14][16:0], win_q[14][31:17]}
                  ^ {win_q[14][18:0], win_q[14][31:19]}
                  ^ (win_q[14] >> 10);
    end

    // W_{t+16} = ssig1(W_{t+14}) + W_{t+9} + ssig0(W_{t+1}) + W_t, mod 2^32.
    // Computed every cycle; it only lands in the window on a transfer.
    assign w_new = ssig1_w14 + win_q[9] + ssig0_w1 + win_q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            t_q     <= 6'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < WinDepth; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // out_ready has no meaning here; only start is looked at.
                    if (start) begin
                        for (int i = 0; i < WinDepth; i++) begin
                            win_q[i] <= block_in[511 - 32*i -: 32];
                        end
                        t_q     <= 6'd0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // start is deliberately ignored mid-block.
                    if (out_ready) begin
                        for (int i = 0; i < WinDepth - 1; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[WinDepth-1] <= w_new;
                        // Wraps 63 -> 0, so round_idx reads 0 back in idle.
                        t_q <= t_q + 6'd1;
                        if (t_q == 6'd63) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are decoded straight from registered state; data is forced to
    // zero outside RUN so idle/reset presents clean zeros.
    always_comb begin
        ready     = (state_q == StIdle);
        valid     = (state_q == StRun);
        w_out     = valid ? win_q[0] : 32'd0;
        k_out     = valid ? KTable[t_q] : 32'd0;
        round_idx = t_q;
        last      = valid && (t_q == 6'd63);
        done      = done_q;
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] block_in;
    logic         ready;
    logic         out_ready;
    logic         valid;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round_idx;
    logic         last;
    logic         done;

    sha256_msg_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .block_in  (block_in),
        .ready     (ready),
        .out_ready (out_ready),
        .valid     (valid),
        .w_out     (w_out),
        .k_out     (k_out),
        .round_idx (round_idx),
        .last      (last),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] KRef [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference model: full 64-word schedule computed up front from the block
    // using the textbook recurrence, plus the round counter / handshake.
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    int          m_t      = 0;
    logic [31:0] m_w [64];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_t      = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    for (int i = 0; i < 16; i++) m_w[i] = block_in[511 - 32*i -: 32];
                    for (int i = 16; i < 64; i++) begin
                        m_w[i] = (rotr(m_w[i-2], 17) ^ rotr(m_w[i-2], 19) ^ (m_w[i-2] >> 10))
                               + m_w[i-7]
                               + (rotr(m_w[i-15], 7) ^ rotr(m_w[i-15], 18) ^ (m_w[i-15] >> 3))
                               + m_w[i-16];
                    end
                    m_t      = 0;
                    m_active = 1'b1;
                end
            end else if (out_ready) begin
                if (m_t == 63) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_t      = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    logic [63:0] log_cur [$];
    logic [63:0] log_a [$];

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(!m_active));
        chk("valid", 32'(valid), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        if (m_active) begin
            chk("w_out", w_out, m_w[m_t]);
            chk("k_out", k_out, KRef[m_t]);
            chk("round_idx", 32'(round_idx), 32'(m_t));
            chk("last", 32'(last), 32'(m_t == 63));
        end else begin
            chk("last_idle", 32'(last), 32'd0);
        end
        if (valid && out_ready) log_cur.push_back({w_out, k_out});
    end

    task automatic start_block(input logic [511:0] b);
        @(posedge clk); #1;
        log_cur.delete();
        start    = 1'b1;
        block_in = b;
        @(posedge clk); #1;
        start    = 1'b0;
        block_in = '0;
    endtask

    task automatic wait_idx(input int idx);
        int n = 0;
        while (!(valid && round_idx == 6'(idx)) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("wait_idx");
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("wait_done");
    endtask

    task automatic cmp_log_a(input string name);
        chk({name, "_len"}, 32'(log_cur.size()), 32'(log_a.size()));
        for (int i = 0; i < log_cur.size() && i < log_a.size(); i++) begin
            chk({name, "_w"}, log_cur[i][63:32], log_a[i][63:32]);
            chk({name, "_k"}, log_cur[i][31:0], log_a[i][31:0]);
        end
    endtask

    logic [511:0] abc_blk;
    logic [511:0] zero_blk;
    logic [511:0] alt_blk;

    initial begin
        int cyc;
        int hits;
        abc_blk  = {32'h61626380, 448'd0, 32'h00000018};
        zero_blk = '0;
        for (int i = 0; i < 16; i++) alt_blk[511 - 32*i -: 32] = 32'h12345678 + 32'h01010101 * i;
        reset     = 1'b1;
        start     = 1'b0;
        block_in  = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_w", w_out, 32'd0);
        chk("rst_k", k_out, 32'd0);
        chk("rst_idx", 32'(round_idx), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_output", 32'(valid), 32'd0);

        // "abc" block with literal pins
        start_block(abc_blk);
        cyc  = 0;
        hits = 0;
        while (!done && cyc < 200) begin
            if (valid) begin
                if (round_idx == 6'd0 && cyc == 0) begin
                    chk("abc_w0", w_out, 32'h61626380);
                    chk("abc_k0", k_out, 32'h428a2f98);
                    hits++;
                end
                if (round_idx == 6'd16) begin
                    chk("abc_w16", w_out, 32'h61626380);
                    chk("abc_k16", k_out, 32'he49b69c1);
                    hits++;
                end
                if (round_idx == 6'd17) begin
                    chk("abc_w17", w_out, 32'h000f0000);
                    hits++;
                end
                if (round_idx == 6'd63) begin
                    chk("abc_k63", k_out, 32'hc67178f2);
                    chk("abc_last63", 32'(last), 32'd1);
                    hits++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("abc_pins_seen", 32'(hits), 32'd4);
        chk("abc_done_latency", 32'(cyc), 32'd64);
        chk("abc_log_len", 32'(log_cur.size()), 32'd64);
        log_a = log_cur;

        // All-zero block
        start_block(zero_blk);
        wait_done();

        // Backpressure at t=5
        start_block(abc_blk);
        wait_idx(5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_idx", 32'(round_idx), 32'd5);
            chk("stall_w", w_out, 32'h00000000);
        end
        out_ready = 1'b1;
        wait_done();
        cmp_log_a("stall");

        // start pulsed mid-run with a different block
        start_block(abc_blk);
        wait_idx(10);
        start    = 1'b1;
        block_in = alt_blk;
        @(posedge clk); #1;
        start    = 1'b0;
        block_in = '0;
        wait_done();
        cmp_log_a("ign_start");

        // Reset at t=30 abandons the block
        start_block(abc_blk);
        wait_idx(30);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_idle", 32'(valid), 32'd0);
        start_block(alt_blk);
        chk("restart_idx", 32'(round_idx), 32'd0);
        chk("restart_w0", w_out, 32'h12345678);
        wait_done();
        chk("restart_len", 32'(log_cur.size()), 32'd64);

        // Start accepted in the done cycle
        start_block(abc_blk);
        wait_done();
        chk("b2b_ready", 32'(ready), 32'd1);
        start    = 1'b1;
        block_in = alt_blk;
        @(posedge clk); #1;
        start    = 1'b0;
        block_in = '0;
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_idx", 32'(round_idx), 32'd0);
        chk("b2b_w0", w_out, 32'h12345678);
        wait_done();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
